// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between the PC/Fetch stage and Decode.
// Each entry holds {instr, pc, pc+4}. A flush from Execute discards queued and incoming
// entries. When the queue is empty, Decode sees a NOP with zero PCs.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward an incoming entry straight
// to Decode while the queue is empty. In the default build there is no combinational
// path from enq_* to deq_*.
module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_valid_i,
  input  logic [DATA_WIDTH-1:0]   enq_instr_i,
  input  logic [DATA_WIDTH-1:0]   enq_pc_i,
  input  logic [DATA_WIDTH-1:0]   enq_pc_plus4_i,
  output logic                    enq_ready_o,
  input  logic                    flush_i,
  output logic                    deq_valid_o,
  output logic [DATA_WIDTH-1:0]   deq_instr_o,
  output logic [DATA_WIDTH-1:0]   deq_pc_o,
  output logic [DATA_WIDTH-1:0]   deq_pc_plus4_o,
  input  logic                    deq_ready_i,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc4;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head, incoming;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          empty, bypass, do_enq, do_deq, push, pop;

  assign incoming    = '{instr: enq_instr_i, pc: enq_pc_i, pc4: enq_pc_plus4_i};
  assign head        = mem[rptr];
  assign empty       = (count == '0);
  assign enq_ready_o = (count < CW'(DEPTH));
  assign count_o     = count;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && enq_valid_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // Present the head entry, the bypassed entry, or a NOP bubble to Decode
  always_comb begin
    deq_valid_o    = 1'b0;
    deq_instr_o    = NOP;
    deq_pc_o       = '0;
    deq_pc_plus4_o = '0;
    if (bypass) begin
      deq_valid_o    = 1'b1;
      deq_instr_o    = incoming.instr;
      deq_pc_o       = incoming.pc;
      deq_pc_plus4_o = incoming.pc4;
    end else if (!empty) begin
      deq_valid_o    = !flush_i;
      deq_instr_o    = head.instr;
      deq_pc_o       = head.pc;
      deq_pc_plus4_o = head.pc4;
    end
  end

  // Handshakes; a bypassed entry that Decode takes is never written or popped
  always_comb begin
    do_enq = enq_valid_i && enq_ready_o && !flush_i;
    do_deq = deq_valid_o && deq_ready_i && !flush_i;
    push   = do_enq && !(bypass && deq_ready_i);
    pop    = do_deq && !bypass;
  end

  // Pointers and occupancy; reset beats flush, flush beats enqueue/dequeue
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wptr] <= incoming;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven directed vectors plus hand sequences for pointer wrap
// and the empty-queue enqueue latency (with or without FETCH_QUEUE_BYPASS_EN).
module tb_fetch_queue;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst, enq_valid, flush, deq_ready, enq_ready, deq_valid;
  logic [DW-1:0] enq_instr, enq_pc, enq_pc4, deq_instr, deq_pc, deq_pc4;
  logic [2:0]    count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .enq_valid_i(enq_valid), .enq_instr_i(enq_instr), .enq_pc_i(enq_pc),
    .enq_pc_plus4_i(enq_pc4), .enq_ready_o(enq_ready), .flush_i(flush),
    .deq_valid_o(deq_valid), .deq_instr_o(deq_instr), .deq_pc_o(deq_pc),
    .deq_pc_plus4_o(deq_pc4), .deq_ready_i(deq_ready), .count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, ev, dr;
    logic [31:0] pc;
    logic        x_valid;
    logic [31:0] x_pc;
    int          x_count;
    logic        x_ready;
  } vec_t;

  vec_t tbl [21];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic ev, input logic dr,
                       input logic [31:0] pc);
    rst = r; flush = f; enq_valid = ev; deq_ready = dr;
    enq_pc = pc; enq_pc4 = pc + 32'd4; enq_instr = instr_of(pc);
  endtask

  // Compare the visible outputs against an expected head/occupancy
  task automatic check_out(input string tag, input logic xv, input logic [31:0] xpc,
                           input int xc, input logic xr);
    check({tag, ".valid"}, {31'd0, deq_valid}, {31'd0, xv});
    check({tag, ".count"}, {29'd0, count}, xc);
    check({tag, ".ready"}, {31'd0, enq_ready}, {31'd0, xr});
    if (xv) begin
      check({tag, ".pc"}, deq_pc, xpc);
      check({tag, ".instr"}, deq_instr, instr_of(xpc));
      check({tag, ".pc4"}, deq_pc4, xpc + 32'd4);
    end else if (xc == 0) begin
      check({tag, ".nop"}, deq_instr, NOP);
      check({tag, ".pc0"}, deq_pc, 32'd0);
      check({tag, ".pc4_0"}, deq_pc4, 32'd0);
    end
  endtask

  logic [31:0] exp_q[$];

  initial begin
    // rst flush ev dr pc  | valid head count ready   (outputs before the edge)
    tbl[0]  = '{0,0,0,0,32'h0,        0,32'h0,        0,1};
    tbl[1]  = '{0,0,1,0,32'hBFC00000, 0,32'h0,        0,1};
    tbl[2]  = '{0,0,1,0,32'hBFC00004, 1,32'hBFC00000, 1,1};
    tbl[3]  = '{0,0,1,0,32'hBFC00008, 1,32'hBFC00000, 2,1};
    tbl[4]  = '{0,0,0,0,32'h0,        1,32'hBFC00000, 3,1};
    tbl[5]  = '{0,0,1,0,32'hBFC0000C, 1,32'hBFC00000, 3,1};
    tbl[6]  = '{0,0,1,0,32'hBFC00010, 1,32'hBFC00000, 4,0};
    tbl[7]  = '{0,0,1,1,32'hBFC00010, 1,32'hBFC00000, 4,0};
    tbl[8]  = '{0,0,0,0,32'h0,        1,32'hBFC00004, 3,1};
    tbl[9]  = '{0,1,1,1,32'hBFC00014, 0,32'h0,        3,1};
    tbl[10] = '{0,0,0,0,32'h0,        0,32'h0,        0,1};
    tbl[11] = '{0,0,1,0,32'h200,      0,32'h0,        0,1};
    tbl[12] = '{0,0,1,0,32'h204,      1,32'h200,      1,1};
    tbl[13] = '{1,0,1,1,32'h208,      1,32'h200,      2,1};
    tbl[14] = '{0,0,0,0,32'h0,        0,32'h0,        0,1};
    tbl[15] = '{0,0,1,0,32'h300,      0,32'h0,        0,1};
    tbl[16] = '{0,0,1,0,32'h304,      1,32'h300,      1,1};
    tbl[17] = '{0,0,1,0,32'h308,      1,32'h300,      2,1};
    tbl[18] = '{0,0,1,0,32'h30C,      1,32'h300,      3,1};
    tbl[19] = '{0,1,0,0,32'h0,        0,32'h0,        4,0};
    tbl[20] = '{0,0,0,0,32'h0,        0,32'h0,        0,1};

    drive(1, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      logic        xv;
      logic [31:0] xp;
      xv = tbl[i].x_valid;
      xp = tbl[i].x_pc;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (!tbl[i].flush && tbl[i].ev && tbl[i].x_count == 0) begin
        xv = 1'b1;
        xp = tbl[i].pc;
      end
`endif
      drive(tbl[i].rst, tbl[i].flush, tbl[i].ev, tbl[i].dr, tbl[i].pc);
      @(negedge clk);
      check_out($sformatf("vec%0d", i), xv, xp, tbl[i].x_count, tbl[i].x_ready);
      @(posedge clk);
      #1;
    end

    // Pointer wrap: hold occupancy at 2 through ten enqueue/dequeue pairs
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 32'h1000 + 32'(4 * i));
      exp_q.push_back(32'h1000 + 32'(4 * i));
      @(posedge clk);
      #1;
    end
    for (int i = 2; i < 12; i++) begin
      drive(0, 0, 1, 1, 32'h1000 + 32'(4 * i));
      @(negedge clk);
      check_out($sformatf("wrap%0d", i), 1'b1, exp_q[0], 2, 1'b1);
      exp_q.pop_front();
      exp_q.push_back(32'h1000 + 32'(4 * i));
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 32'h0);
      @(negedge clk);
      check_out($sformatf("drain%0d", i), 1'b1, exp_q[0], 2 - i, 1'b1);
      exp_q.pop_front();
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 32'h0);
    @(negedge clk);
    check_out("drained", 1'b0, 32'h0, 0, 1'b1);
    @(posedge clk);
    #1;

    // Empty-queue enqueue of PC 0x100 with Decode ready
    drive(0, 0, 1, 1, 32'h100);
    @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
    check_out("byp.same", 1'b1, 32'h100, 0, 1'b1);
`else
    check_out("lat.same", 1'b0, 32'h0, 0, 1'b1);
`endif
    @(posedge clk);
    #1;
    drive(0, 0, 0, 1, 32'h0);
    @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
    check_out("byp.next", 1'b0, 32'h0, 0, 1'b1);
`else
    check_out("lat.next", 1'b1, 32'h100, 1, 1'b1);
`endif
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 32'h0);
    @(negedge clk);
    check_out("final", 1'b0, 32'h0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the instruction and PC fields.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of entries; legal values are powers of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port enq_valid_i, input, 1 bit: the fetched instruction and its PC are valid this cycle.
REQ-006 SHALL have port enq_instr_i, input, DATA_WIDTH: fetched instruction word.
REQ-007 SHALL have port enq_pc_i, input, DATA_WIDTH: PC of the fetched instruction.
REQ-008 SHALL have port enq_pc_plus4_i, input, DATA_WIDTH: PC+4 of the fetched instruction.
REQ-009 SHALL have port enq_ready_o, output, 1 bit: queue can accept an entry; the PC stage holds its PC while this is low.
REQ-010 SHALL have port flush_i, input, 1 bit: redirect (branch/jump taken in Execute); discards queued and incoming entries.
REQ-011 SHALL have port deq_valid_o, output, 1 bit: the head entry is presented to Decode.
REQ-012 SHALL have port deq_instr_o, output, DATA_WIDTH: instruction of the head entry.
REQ-013 SHALL have port deq_pc_o, output, DATA_WIDTH: PC of the head entry.
REQ-014 SHALL have port deq_pc_plus4_o, output, DATA_WIDTH: PC+4 of the head entry.
REQ-015 SHALL have port deq_ready_i, input, 1 bit: Decode accepts the head entry this cycle.
REQ-016 SHALL have port count_o, output, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-017 Enqueue SHALL occur when enq_valid_i=1, enq_ready_o=1 and flush_i=0; the entry is written at the write pointer.
REQ-018 Dequeue SHALL occur when deq_valid_o=1, deq_ready_i=1 and flush_i=0; the read pointer advances.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH.
REQ-020 enq_ready_o SHALL equal (count_o < DEPTH); a full queue rejects enqueue even when a dequeue occurs in the same cycle.
REQ-021 Occupancy state SHALL be EMPTY (count 0), PARTIAL, or FULL (count DEPTH): enqueue only gives +1, dequeue only gives -1, both give no change.
REQ-022 When not empty, deq_valid_o SHALL be 1 and deq_* SHALL show the head entry unchanged until it is dequeued.
REQ-023 When empty (and not bypassing), deq_valid_o SHALL be 0, deq_instr_o SHALL be 0x00000013 (NOP), and deq_pc_o and deq_pc_plus4_o SHALL be 0.
REQ-024 flush_i=1 SHALL force deq_valid_o=0 in the same cycle and set count and both pointers to 0 at the next edge; the same-cycle enqueue is dropped.
REQ-025 flush_i SHALL take priority over enqueue and dequeue; a flush while full SHALL yield count 0 and enq_ready_o=1 in the next cycle.
REQ-026 With the bypass option disabled, latency from enqueue to deq_valid_o SHALL be exactly one cycle.

Reset
REQ-027 rst=1 SHALL at the next edge set count_o=0, both pointers to 0, deq_valid_o=0, enq_ready_o=1, deq_instr_o=0x00000013, deq_pc_o=0, deq_pc_plus4_o=0.
REQ-028 rst SHALL take priority over flush_i, enqueue and dequeue; asserting it mid-operation discards all entries; storage contents need not be cleared.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN SHALL select the bypass feature.
REQ-030 Defined: when count=0, enq_valid_i=1 and flush_i=0, deq_* SHALL show the incoming entry combinationally with deq_valid_o=1; if deq_ready_i=1 the entry is consumed and not written (count stays 0); otherwise it is written normally.
REQ-031 Undefined: no combinational path from enq_* to deq_*; REQ-026 applies.

Verification
REQ-032 Reset, then enqueue PC 0xBFC00000/0xBFC00004/0xBFC00008 with deq_ready_i=0 -> count_o=3; deq_pc_o=0xBFC00000 held.
REQ-033 DEPTH=4: five back-to-back enqueues with deq_ready_i=0 -> enq_ready_o=0 after the fourth; the fifth is not stored; count_o=4.
REQ-034 Full queue: enq_valid_i=1 and deq_ready_i=1 for one cycle -> one dequeue, no enqueue, count_o=3, enq_ready_o=1 next cycle.
REQ-035 count_o=3, flush_i=1 with enq_valid_i=1 -> deq_valid_o=0 that cycle; next cycle count_o=0, deq_instr_o=0x00000013.
REQ-036 Ten enqueue/dequeue pairs at occupancy 2 -> pointers wrap; output PC order matches input order exactly.
REQ-037 Empty queue, enqueue PC 0x100 with deq_ready_i=1 -> BYPASS_EN: deq_pc_o=0x100 same cycle and count_o stays 0; without: deq_pc_o=0x100 with deq_valid_o=1 the next cycle.
